lpif_txrx_gearbox: RTL and testbench
====================================

# lpif_txrx_gearbox

Parametrised LPIF-to-logic-link gearbox replacing fixed-ratio combinational lane mappers. TX side collects RATIO consecutive single-slot LPIF upstream beats into one wide word and pushes it into the TX FIFO under backpressure. RX side pops wide words from the RX FIFO and replays them as RATIO downstream beats under a valid/ready handshake. Sits between the LPIF adapter and the logic-link TX/RX FIFOs in the lclk domain.

## Interface
- DW, 64: data bits per slot.
- CW, 2: CRC bits per slot.
- RATIO, 2: slots per FIFO word in gen2 mode (1, 2 or 4).
- SLOT_W, DW+CW+9: derived, not overridable. Layout: state[0+:4], protid[4+:2], data[6+:DW], dvalid, crc[CW], crc_valid, valid (low to high).
- WORD_W, RATIO*SLOT_W: derived. Slot k occupies [k*SLOT_W +: SLOT_W].

Ports:
- lclk  in  1  logic-link clock; single clock domain.
- lrst  in  1  reset, asynchronous, active-high.
- m_gen2_mode  in  1  1: RATIO slots per word; 0: max(RATIO/2,1) slots per word.
- ustrm_slot  in  SLOT_W  upstream LPIF beat.
- ustrm_vld  in  1  beat valid.
- ustrm_rdy  out  1  beat accepted when vld&rdy.
- txfifo_wdata  out  WORD_W  packed word.
- txfifo_push  out  1  write strobe.
- txfifo_full  in  1  FIFO cannot accept.
- rxfifo_rdata  in  WORD_W  show-ahead read data, valid while !rxfifo_empty.
- rxfifo_empty  in  1  FIFO empty.
- rxfifo_pop  out  1  read strobe.
- dstrm_slot  out  SLOT_W  downstream LPIF beat.
- dstrm_vld  out  1  beat valid.
- dstrm_rdy  in  1  consumer accepts.

## Operation
- Mode: mode_q registers m_gen2_mode only when TX slot count is 0, TX output register is empty, RX holding register is empty and dstrm_vld=0; otherwise the input is ignored. N = RATIO if mode_q else max(RATIO/2,1). Reset: mode_q=1.
- TX: slot counter tx_cnt (0..N-1). Each accepted beat is written to assembly slot tx_cnt, then tx_cnt increments. Acceptance of slot N-1 copies the assembly (unused slots N..RATIO-1 zero) into output register, sets tx_out_vld and wraps tx_cnt to 0.
- txfifo_push = tx_out_vld & !txfifo_full; push clears tx_out_vld unless a new word loads that same cycle.
- ustrm_rdy = !(tx_out_vld & txfifo_full). Same rule for every slot.
- RX: holding register rx_word with rx_cnt (0..N-1) and dstrm_vld. dstrm_slot = rx_word slot rx_cnt. On vld&rdy rx_cnt increments; after slot N-1, rx_cnt wraps to 0.
- rxfifo_pop = !rxfifo_empty & (!dstrm_vld | (dstrm_rdy & rx_cnt==N-1)). Pop loads rx_word and sets dstrm_vld. Last-slot consume with no pop clears dstrm_vld.
- Slot valid field is payload only; it is not a handshake.

## Timing
- Reset values: ustrm_rdy=1, txfifo_push=0, txfifo_wdata=0, rxfifo_pop=0, dstrm_vld=0, dstrm_slot=0, counters 0.
- Outputs ustrm_rdy, txfifo_push and rxfifo_pop are combinational from registers and FIFO flags. All other outputs are registered.
- TX latency: last slot accepted at cycle t -> txfifo_push at t+1 if !txfifo_full. Sustained throughput is 1 beat/cycle.
- RX latency: pop at t -> first slot on dstrm at t+1. Back-to-back words have no bubble.
- Full with tx_out_vld: stall all TX beats; the assembly holds.
- Empty: dstrm_vld deasserts after the last slot; rx_cnt is 0.
- Asynchronous reset mid-word discards partial assembly and holding contents. No push or pop is issued in the reset cycle.

## Structure
- Package lpif_gbx_pkg holds SLOT_W/WORD_W functions, field offset constants (STATE_OFS, PROTID_OFS, DATA_OFS, ...) and the slot-count function n_slots(ratio, gen2).
- One sub-module, lpif_gbx_slot_ctr: enable, mode-dependent wrap at N-1, last-flag output. Instantiated once for TX and once for RX.

## Test plan
- DW=64, RATIO=2, gen2. Feed beats A, B with rxfifo idle -> one push at cycle after B, txfifo_wdata={B,A}, WORD_W=150.
- txfifo_full=1 with a word pending. Offer C, D -> ustrm_rdy=0, no push. Release full -> pushes pending word, then {D,C}; no beat is lost.
- RX FIFO holds words W0, W1. Tie dstrm_rdy=1 -> four consecutive beats W0.s0, W0.s1, W1.s0, W1.s1. Pops occur at first cycle and at W0.s1 consume.
- RATIO=4, m_gen2_mode=0 -> 2 slots per word, slots 2-3 written as zero. Toggle mode mid-word -> ignored until idle.
- dstrm_rdy toggles 1010 -> each slot is held stable while rdy=0, and order is preserved.
- Assert lrst after one of two TX slots -> no push. Next A, B produce {B,A}, and the stale slot is absent.

Source files
------------

// File: rtl/lpif_gbx_pkg.sv
// Shared slot layout, word sizing and mode-dependent slot-count helpers
// for the LPIF/logic-link gearbox.
package lpif_gbx_pkg;

    // Slot fields, packed low to high: state, protid, data, dvalid, crc, crc_valid, valid
    localparam int STATE_OFS  = 0;
    localparam int PROTID_OFS = 4;
    localparam int DATA_OFS   = 6;

    function automatic int slot_w(input int dw, input int cw);
        return dw + cw + 9;
    endfunction

    function automatic int word_w(input int ratio, input int sw);
        return ratio * sw;
    endfunction

    function automatic int dvalid_ofs(input int dw);
        return DATA_OFS + dw;
    endfunction

    function automatic int crc_ofs(input int dw);
        return DATA_OFS + dw + 1;
    endfunction

    function automatic int crcv_ofs(input int dw, input int cw);
        return DATA_OFS + dw + 1 + cw;
    endfunction

    function automatic int valid_ofs(input int dw, input int cw);
        return DATA_OFS + dw + 2 + cw;
    endfunction

    function automatic int n_slots(input int ratio, input logic gen2);
        if (gen2)
            return ratio;
        return (ratio / 2 > 1) ? ratio / 2 : 1;
    endfunction

endpackage

// File: rtl/lpif_gbx_slot_ctr.sv
// Slot index counter: advances on enable and wraps after the mode-dependent
// last slot index; flags when the current slot is the last one.
module lpif_gbx_slot_ctr #(
    parameter int CNT_W = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_last_idx,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_last
);

    logic [CNT_W-1:0] r_cnt;

    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == i_last_idx);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= o_last ? '0 : r_cnt + 1'b1;
    end

endmodule

// File: rtl/lpif_txrx_gearbox.sv
// LPIF <-> logic-link gearbox: packs N upstream slots into one TX FIFO word and
// replays each RX FIFO word as N downstream slots (N = RATIO or RATIO/2 by mode).
module lpif_txrx_gearbox
    import lpif_gbx_pkg::*;
#(
    parameter int  DW     = 64,
    parameter int  CW     = 2,
    parameter int  RATIO  = 2,
    localparam int SLOT_W = slot_w(DW, CW),
    localparam int WORD_W = word_w(RATIO, SLOT_W)
) (
    input  logic              lclk,
    input  logic              lrst,
    input  logic              m_gen2_mode,
    input  logic [SLOT_W-1:0] ustrm_slot,
    input  logic              ustrm_vld,
    output logic              ustrm_rdy,
    output logic [WORD_W-1:0] txfifo_wdata,
    output logic              txfifo_push,
    input  logic              txfifo_full,
    input  logic [WORD_W-1:0] rxfifo_rdata,
    input  logic              rxfifo_empty,
    output logic              rxfifo_pop,
    output logic [SLOT_W-1:0] dstrm_slot,
    output logic              dstrm_vld,
    input  logic              dstrm_rdy
);

    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic                         r_mode;
    logic [CNT_W-1:0]             w_last_idx;
    logic [CNT_W-1:0]             w_tx_cnt;
    logic [CNT_W-1:0]             w_rx_cnt;
    logic [CNT_W-1:0]             w_rx_nxt;
    logic                         w_tx_last;
    logic                         w_rx_last;
    logic                         w_tx_acc;
    logic                         w_rx_take;
    logic                         w_idle;
    logic [RATIO-1:0][SLOT_W-1:0] r_tx_asm;
    logic [RATIO-1:0][SLOT_W-1:0] r_tx_out;
    logic [RATIO-1:0][SLOT_W-1:0] w_tx_word;
    logic [RATIO-1:0][SLOT_W-1:0] r_rx_word;
    logic                         r_tx_out_vld;
    logic                         r_dstrm_vld;
    logic [SLOT_W-1:0]            r_dstrm_slot;

    assign w_last_idx   = CNT_W'(n_slots(RATIO, r_mode) - 1);
    assign ustrm_rdy    = !(r_tx_out_vld && txfifo_full);
    assign w_tx_acc     = ustrm_vld && ustrm_rdy;
    assign txfifo_push  = r_tx_out_vld && !txfifo_full;
    assign txfifo_wdata = r_tx_out;
    assign w_rx_take    = r_dstrm_vld && dstrm_rdy;
    assign w_rx_nxt     = w_rx_cnt + 1'b1;
    assign rxfifo_pop   = !lrst && !rxfifo_empty && (!r_dstrm_vld || (dstrm_rdy && w_rx_last));
    assign dstrm_vld    = r_dstrm_vld;
    assign dstrm_slot   = r_dstrm_slot;

    // A beat or pop landing in the same cycle is still counted with the old N,
    // so the mode only switches on a cycle with no transfer at all.
    assign w_idle = (w_tx_cnt == '0) && !r_tx_out_vld && !r_dstrm_vld && !w_tx_acc && !rxfifo_pop;

    always_ff @(posedge lclk or posedge lrst) begin
        if (lrst)
            r_mode <= 1'b1;
        else if (w_idle)
            r_mode <= m_gen2_mode;
    end

    lpif_gbx_slot_ctr #(.CNT_W(CNT_W)) u_tx_ctr (
        .i_clk      (lclk),
        .i_rst      (lrst),
        .i_en       (w_tx_acc),
        .i_last_idx (w_last_idx),
        .o_cnt      (w_tx_cnt),
        .o_last     (w_tx_last)
    );

    lpif_gbx_slot_ctr #(.CNT_W(CNT_W)) u_rx_ctr (
        .i_clk      (lclk),
        .i_rst      (lrst),
        .i_en       (w_rx_take),
        .i_last_idx (w_last_idx),
        .o_cnt      (w_rx_cnt),
        .o_last     (w_rx_last)
    );

    // Completed word: the beat being accepted lands in its slot directly, unused slots read zero
    always_comb begin
        w_tx_word = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (k <= int'(w_last_idx))
                w_tx_word[k] = (k == int'(w_tx_cnt)) ? ustrm_slot : r_tx_asm[k];
        end
    end

    always_ff @(posedge lclk or posedge lrst) begin
        if (lrst) begin
            r_tx_asm     <= '0;
            r_tx_out     <= '0;
            r_tx_out_vld <= 1'b0;
        end else begin
            if (w_tx_acc)
                r_tx_asm[w_tx_cnt] <= ustrm_slot;
            if (w_tx_acc && w_tx_last) begin
                r_tx_out     <= w_tx_word;
                r_tx_out_vld <= 1'b1;
            end else if (txfifo_push) begin
                r_tx_out_vld <= 1'b0;
            end
        end
    end

    // RX: the next slot is registered ahead so dstrm_slot comes straight from a flop
    always_ff @(posedge lclk or posedge lrst) begin
        if (lrst) begin
            r_rx_word    <= '0;
            r_dstrm_vld  <= 1'b0;
            r_dstrm_slot <= '0;
        end else if (rxfifo_pop) begin
            r_rx_word    <= rxfifo_rdata;
            r_dstrm_vld  <= 1'b1;
            r_dstrm_slot <= rxfifo_rdata[SLOT_W-1:0];
        end else if (w_rx_take) begin
            if (w_rx_last)
                r_dstrm_vld <= 1'b0;
            else
                r_dstrm_slot <= r_rx_word[w_rx_nxt];
        end
    end

endmodule

// File: tb/tb_lpif_txrx_gearbox.sv
// Directed bench for lpif_txrx_gearbox: RATIO=2 instance for TX/RX paths and
// reset, RATIO=4 instance for the reduced-slot mode and guarded mode switch.
`timescale 1ns/1ps
module tb_lpif_txrx_gearbox;
    import lpif_gbx_pkg::*;

    localparam int DW = 64;
    localparam int CW = 2;
    localparam int SW = DW + CW + 9;
    typedef logic [SW-1:0] slot_t;

    logic lclk = 1'b0;
    logic lrst;

    logic            a_gen2, a_uvld, a_urdy, a_push, a_full, a_empty, a_pop, a_dvld, a_drdy;
    slot_t           a_uslot, a_dslot;
    logic [2*SW-1:0] a_wdata, a_rdata;

    logic            b_gen2, b_uvld, b_urdy, b_push, b_full, b_empty, b_pop, b_dvld, b_drdy;
    slot_t           b_uslot, b_dslot;
    logic [4*SW-1:0] b_wdata, b_rdata;

    int total = 0;
    int bad   = 0;

    always #5 lclk = ~lclk;

    lpif_txrx_gearbox #(.DW(DW), .CW(CW), .RATIO(2)) u2 (
        .lclk(lclk), .lrst(lrst), .m_gen2_mode(a_gen2),
        .ustrm_slot(a_uslot), .ustrm_vld(a_uvld), .ustrm_rdy(a_urdy),
        .txfifo_wdata(a_wdata), .txfifo_push(a_push), .txfifo_full(a_full),
        .rxfifo_rdata(a_rdata), .rxfifo_empty(a_empty), .rxfifo_pop(a_pop),
        .dstrm_slot(a_dslot), .dstrm_vld(a_dvld), .dstrm_rdy(a_drdy)
    );

    lpif_txrx_gearbox #(.DW(DW), .CW(CW), .RATIO(4)) u4 (
        .lclk(lclk), .lrst(lrst), .m_gen2_mode(b_gen2),
        .ustrm_slot(b_uslot), .ustrm_vld(b_uvld), .ustrm_rdy(b_urdy),
        .txfifo_wdata(b_wdata), .txfifo_push(b_push), .txfifo_full(b_full),
        .rxfifo_rdata(b_rdata), .rxfifo_empty(b_empty), .rxfifo_pop(b_pop),
        .dstrm_slot(b_dslot), .dstrm_vld(b_dvld), .dstrm_rdy(b_drdy)
    );

    function automatic slot_t mk(input logic [7:0] t);
        slot_t s;
        s = '0;
        s[STATE_OFS +: 4]       = t[3:0];
        s[PROTID_OFS +: 2]      = t[5:4];
        s[DATA_OFS +: DW]       = {8{t}};
        s[dvalid_ofs(DW)]       = t[0];
        s[crc_ofs(DW) +: CW]    = t[7:6];
        s[crcv_ofs(DW, CW)]     = t[1];
        s[valid_ofs(DW, CW)]    = 1'b1;
        return s;
    endfunction

    task automatic tick;
        @(posedge lclk);
        #1;
    endtask

    task automatic test_reset;
        lrst    = 1'b1;
        a_empty = 1'b0;
        a_rdata = {mk(8'h11), mk(8'h10)};
        tick();
        tick();
        total++; if (a_urdy !== 1'b1) begin bad++; $display("FAIL rst_urdy got=%b exp=1", a_urdy); end
        total++; if (a_push !== 1'b0) begin bad++; $display("FAIL rst_push got=%b exp=0", a_push); end
        total++; if (a_wdata !== '0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", a_wdata); end
        total++; if (a_pop !== 1'b0) begin bad++; $display("FAIL rst_pop got=%b exp=0", a_pop); end
        total++; if (a_dvld !== 1'b0) begin bad++; $display("FAIL rst_dvld got=%b exp=0", a_dvld); end
        total++; if (a_dslot !== '0) begin bad++; $display("FAIL rst_dslot got=%h exp=0", a_dslot); end
        total++; if (b_urdy !== 1'b1) begin bad++; $display("FAIL rst_urdy4 got=%b exp=1", b_urdy); end
        lrst    = 1'b0;
        a_empty = 1'b1;
        a_rdata = '0;
        tick();
    endtask

    task automatic test_tx_basic;
        a_uvld = 1'b1; a_uslot = mk(8'hA0);
        #1;
        total++; if (a_urdy !== 1'b1) begin bad++; $display("FAIL txb_rdyA got=%b exp=1", a_urdy); end
        total++; if (a_push !== 1'b0) begin bad++; $display("FAIL txb_pushA got=%b exp=0", a_push); end
        tick();
        a_uslot = mk(8'hB1);
        #1;
        total++; if (a_urdy !== 1'b1) begin bad++; $display("FAIL txb_rdyB got=%b exp=1", a_urdy); end
        total++; if (a_push !== 1'b0) begin bad++; $display("FAIL txb_pushB got=%b exp=0", a_push); end
        tick();
        a_uvld = 1'b0;
        #1;
        total++; if (a_push !== 1'b1) begin bad++; $display("FAIL txb_push got=%b exp=1", a_push); end
        total++; if (a_wdata !== {mk(8'hB1), mk(8'hA0)}) begin bad++; $display("FAIL txb_word got=%h exp=%h", a_wdata, {mk(8'hB1), mk(8'hA0)}); end
        tick();
        total++; if (a_push !== 1'b0) begin bad++; $display("FAIL txb_once got=%b exp=0", a_push); end
    endtask

    task automatic test_backpressure;
        a_full = 1'b1;
        a_uvld = 1'b1; a_uslot = mk(8'hE4);
        tick();
        a_uslot = mk(8'hF5);
        tick();
        a_uslot = mk(8'hC2);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (a_urdy !== 1'b0) begin bad++; $display("FAIL bp_rdy%0d got=%b exp=0", i, a_urdy); end
            total++; if (a_push !== 1'b0) begin bad++; $display("FAIL bp_push%0d got=%b exp=0", i, a_push); end
            tick();
        end
        a_full = 1'b0;
        #1;
        total++; if (a_push !== 1'b1) begin bad++; $display("FAIL bp_rel_push got=%b exp=1", a_push); end
        total++; if (a_urdy !== 1'b1) begin bad++; $display("FAIL bp_rel_rdy got=%b exp=1", a_urdy); end
        total++; if (a_wdata !== {mk(8'hF5), mk(8'hE4)}) begin bad++; $display("FAIL bp_word1 got=%h exp=%h", a_wdata, {mk(8'hF5), mk(8'hE4)}); end
        tick();
        a_uslot = mk(8'hD3);
        #1;
        total++; if (a_push !== 1'b0) begin bad++; $display("FAIL bp_mid_push got=%b exp=0", a_push); end
        tick();
        a_uvld = 1'b0;
        #1;
        total++; if (a_push !== 1'b1) begin bad++; $display("FAIL bp_push2 got=%b exp=1", a_push); end
        total++; if (a_wdata !== {mk(8'hD3), mk(8'hC2)}) begin bad++; $display("FAIL bp_word2 got=%h exp=%h", a_wdata, {mk(8'hD3), mk(8'hC2)}); end
        tick();
        total++; if (a_push !== 1'b0) begin bad++; $display("FAIL bp_done got=%b exp=0", a_push); end
    endtask

    task automatic test_back_to_back;
        logic [2*SW-1:0] w [2];
        slot_t           es [6];
        logic [5:0]      ev;
        logic [5:0]      ep;
        int              idx;
        logic            popped;
        w[0] = {mk(8'h21), mk(8'h20)};
        w[1] = {mk(8'h31), mk(8'h30)};
        es   = '{'0, mk(8'h20), mk(8'h21), mk(8'h30), mk(8'h31), '0};
        ev   = 6'b011110;
        ep   = 6'b000101;
        idx  = 0;
        a_drdy = 1'b1; a_rdata = w[0]; a_empty = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            total++; if (a_pop !== ep[c]) begin bad++; $display("FAIL b2b_pop%0d got=%b exp=%b", c, a_pop, ep[c]); end
            total++; if (a_dvld !== ev[c]) begin bad++; $display("FAIL b2b_vld%0d got=%b exp=%b", c, a_dvld, ev[c]); end
            if (ev[c]) begin
                total++; if (a_dslot !== es[c]) begin bad++; $display("FAIL b2b_slot%0d got=%h exp=%h", c, a_dslot, es[c]); end
            end
            popped = a_pop;
            tick();
            if (popped) begin
                idx++;
                if (idx < 2) a_rdata = w[idx];
                else begin a_empty = 1'b1; a_rdata = '0; end
            end
        end
    endtask

    task automatic test_rdy_toggle;
        logic [2*SW-1:0] w [2];
        slot_t           es [9];
        logic [8:0]      rdy;
        logic [8:0]      ev;
        logic [8:0]      ep;
        int              idx;
        logic            popped;
        w[0] = {mk(8'h41), mk(8'h40)};
        w[1] = {mk(8'h51), mk(8'h50)};
        es   = '{'0, mk(8'h40), mk(8'h41), mk(8'h41), mk(8'h50), mk(8'h50), mk(8'h51), mk(8'h51), '0};
        rdy  = 9'b010101010;
        ev   = 9'b011111110;
        ep   = 9'b000001001;
        idx  = 0;
        a_rdata = w[0]; a_empty = 1'b0;
        for (int c = 0; c < 9; c++) begin
            a_drdy = rdy[c];
            #1;
            total++; if (a_pop !== ep[c]) begin bad++; $display("FAIL tog_pop%0d got=%b exp=%b", c, a_pop, ep[c]); end
            total++; if (a_dvld !== ev[c]) begin bad++; $display("FAIL tog_vld%0d got=%b exp=%b", c, a_dvld, ev[c]); end
            if (ev[c]) begin
                total++; if (a_dslot !== es[c]) begin bad++; $display("FAIL tog_slot%0d got=%h exp=%h", c, a_dslot, es[c]); end
            end
            popped = a_pop;
            tick();
            if (popped) begin
                idx++;
                if (idx < 2) a_rdata = w[idx];
                else begin a_empty = 1'b1; a_rdata = '0; end
            end
        end
        a_drdy = 1'b0;
    endtask

    task automatic test_ratio4_mode;
        logic [4*SW-1:0] e4;
        b_gen2 = 1'b0; b_uvld = 1'b0;
        tick();
        b_uvld = 1'b1; b_uslot = mk(8'h80);
        tick();
        b_uslot = mk(8'h81);
        tick();
        b_uvld = 1'b0;
        #1;
        e4 = {slot_t'(0), slot_t'(0), mk(8'h81), mk(8'h80)};
        total++; if (b_push !== 1'b1) begin bad++; $display("FAIL r4_push1 got=%b exp=1", b_push); end
        total++; if (b_wdata !== e4) begin bad++; $display("FAIL r4_word1 got=%h exp=%h", b_wdata, e4); end
        tick();
        b_uvld = 1'b1; b_uslot = mk(8'h90);
        tick();
        b_uvld = 1'b0; b_gen2 = 1'b1;
        tick();
        tick();
        total++; if (b_push !== 1'b0) begin bad++; $display("FAIL r4_midword got=%b exp=0", b_push); end
        b_uvld = 1'b1; b_uslot = mk(8'h91);
        tick();
        b_uvld = 1'b0;
        #1;
        e4 = {slot_t'(0), slot_t'(0), mk(8'h91), mk(8'h90)};
        total++; if (b_push !== 1'b1) begin bad++; $display("FAIL r4_push2 got=%b exp=1", b_push); end
        total++; if (b_wdata !== e4) begin bad++; $display("FAIL r4_word2 got=%h exp=%h", b_wdata, e4); end
        tick();
        tick();
        b_uvld = 1'b1;
        for (int k = 0; k < 4; k++) begin
            b_uslot = mk(8'hC0 + 8'(k));
            #1;
            total++; if (b_push !== 1'b0) begin bad++; $display("FAIL r4_gen2_nopush%0d got=%b exp=0", k, b_push); end
            tick();
        end
        b_uvld = 1'b0;
        #1;
        e4 = {mk(8'hC3), mk(8'hC2), mk(8'hC1), mk(8'hC0)};
        total++; if (b_push !== 1'b1) begin bad++; $display("FAIL r4_push3 got=%b exp=1", b_push); end
        total++; if (b_wdata !== e4) begin bad++; $display("FAIL r4_word3 got=%h exp=%h", b_wdata, e4); end
        tick();
    endtask

    task automatic test_reset_midword;
        a_uvld = 1'b1; a_uslot = mk(8'h66);
        tick();
        a_uvld = 1'b0;
        #1;
        lrst = 1'b1;
        #1;
        total++; if (a_push !== 1'b0) begin bad++; $display("FAIL rmw_push_rst got=%b exp=0", a_push); end
        tick();
        lrst = 1'b0;
        tick();
        total++; if (a_push !== 1'b0) begin bad++; $display("FAIL rmw_push_after got=%b exp=0", a_push); end
        a_uvld = 1'b1; a_uslot = mk(8'h70);
        tick();
        a_uslot = mk(8'h71);
        #1;
        total++; if (a_push !== 1'b0) begin bad++; $display("FAIL rmw_stale got=%b exp=0", a_push); end
        tick();
        a_uvld = 1'b0;
        #1;
        total++; if (a_push !== 1'b1) begin bad++; $display("FAIL rmw_push got=%b exp=1", a_push); end
        total++; if (a_wdata !== {mk(8'h71), mk(8'h70)}) begin bad++; $display("FAIL rmw_word got=%h exp=%h", a_wdata, {mk(8'h71), mk(8'h70)}); end
        tick();
    endtask

    initial begin
        lrst    = 1'b0;
        a_gen2  = 1'b1; a_uvld = 1'b0; a_uslot = '0; a_full = 1'b0;
        a_empty = 1'b1; a_rdata = '0; a_drdy = 1'b0;
        b_gen2  = 1'b1; b_uvld = 1'b0; b_uslot = '0; b_full = 1'b0;
        b_empty = 1'b1; b_rdata = '0; b_drdy = 1'b0;
        #2;
        test_reset();
        test_tx_basic();
        test_backpressure();
        test_back_to_back();
        test_rdy_toggle();
        test_ratio4_mode();
        test_reset_midword();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
